// File: rtl/ahb3lite_rr_master_arb.sv
// Two-port round-robin arbiter driving one AHB3-Lite master port, one SINGLE transfer at a time.
// Define AHB_ARB_FIXED_PRIO_EN to make port 0 win every contention (port 1 may starve).

module ahb3lite_rr_cmd_chk #(
  parameter int HDATA_SIZE = 32
)(
  input  logic [6:0] addr_lo_i,
  input  logic [2:0] size_i,
  output logic       illegal_o
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(HDATA_SIZE/8));

  logic [6:0] mask;

  always_comb begin
    mask      = 7'((8'd1 << size_i) - 8'd1);
    illegal_o = (size_i > MAX_SIZE) || (|(addr_lo_i & mask));
  end
endmodule

module ahb3lite_rr_master_arb #(
  parameter int          HADDR_SIZE = 32,
  parameter int          HDATA_SIZE = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
)(
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [HADDR_SIZE-1:0] req0_addr,
  input  logic [HDATA_SIZE-1:0] req0_wdata,
  input  logic [2:0]            req0_size,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [HADDR_SIZE-1:0] req1_addr,
  input  logic [HDATA_SIZE-1:0] req1_wdata,
  input  logic [2:0]            req1_size,
  output logic                  rsp0_valid,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic                  rsp1_err,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, REJ} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  // Per-port command view, indexed by port number.
  logic [1:0]                 vld, wr, illegal;
  logic [1:0][HADDR_SIZE-1:0] addr;
  logic [1:0][HDATA_SIZE-1:0] wdata;
  logic [1:0][2:0]            size;

  assign vld   = {req1_valid, req0_valid};
  assign wr    = {req1_write, req0_write};
  assign addr  = {req1_addr,  req0_addr};
  assign wdata = {req1_wdata, req0_wdata};
  assign size  = {req1_size,  req0_size};

  for (genvar p = 0; p < 2; p++) begin : g_chk
    ahb3lite_rr_cmd_chk #(.HDATA_SIZE(HDATA_SIZE)) u_chk (
      .addr_lo_i (addr[p][6:0]),
      .size_i    (size[p]),
      .illegal_o (illegal[p])
    );
  end

  state_t                 state_q;
  logic                   last_grant_q;
  logic                   port_q;
  logic                   wr_q;
  logic [HDATA_SIZE-1:0]  wdata_q;
  logic                   hsel_q;
  logic [HADDR_SIZE-1:0]  haddr_q;
  logic [HDATA_SIZE-1:0]  hwdata_q;
  logic                   hwrite_q;
  logic [2:0]             hsize_q;
  logic [3:0]             hprot_q;
  logic [1:0]             htrans_q;
  logic [1:0]             rsp_vld_q, rsp_err_q;
  logic [HDATA_SIZE-1:0]  rdata_q;

  logic gnt_any, gnt_sel;

  // Grant only in IDLE; ready is combinational so the requester sees it in the accept cycle.
  always_comb begin
    gnt_any = (state_q == IDLE) && !HRESET && (|vld);
`ifdef AHB_ARB_FIXED_PRIO_EN
    gnt_sel = !vld[0];
`else
    if (&vld) gnt_sel = ~last_grant_q;
    else      gnt_sel = vld[1];
`endif
  end

  assign req0_ready = gnt_any & ~gnt_sel;
  assign req1_ready = gnt_any &  gnt_sel;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      hsel_q       <= 1'b0;
      haddr_q      <= '0;
      hwdata_q     <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      hprot_q      <= '0;
      htrans_q     <= HT_IDLE;
      rsp_vld_q    <= '0;
      rsp_err_q    <= '0;
      rdata_q      <= '0;
    end else begin
      rsp_vld_q <= '0;
      rsp_err_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            port_q       <= gnt_sel;
            last_grant_q <= gnt_sel;
            wr_q         <= wr[gnt_sel];
            wdata_q      <= wdata[gnt_sel];
            if (illegal[gnt_sel]) begin
              // Rejected locally: the bus never sees this command.
              rsp_vld_q[gnt_sel] <= 1'b1;
              rsp_err_q[gnt_sel] <= 1'b1;
              rdata_q            <= '0;
              state_q            <= REJ;
            end else begin
              hsel_q   <= 1'b1;
              htrans_q <= HT_NONSEQ;
              haddr_q  <= addr[gnt_sel];
              hwrite_q <= wr[gnt_sel];
              hsize_q  <= size[gnt_sel];
              hprot_q  <= HPROT_VAL;
              state_q  <= ADDR;
            end
          end
        end
        ADDR: begin
          if (HREADY) begin
            hsel_q   <= 1'b0;
            htrans_q <= HT_IDLE;
            hwdata_q <= wr_q ? wdata_q : '0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          // The first HRESP cycle has HREADY low, so only the final cycle completes.
          if (HREADY) begin
            rsp_vld_q[port_q] <= 1'b1;
            rsp_err_q[port_q] <= HRESP;
            rdata_q           <= wr_q ? '0 : HRDATA;
            state_q           <= IDLE;
          end
        end
        REJ:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HSEL       = hsel_q;
  assign HADDR      = haddr_q;
  assign HWDATA     = hwdata_q;
  assign HWRITE     = hwrite_q;
  assign HSIZE      = hsize_q;
  assign HBURST     = 3'b000;
  assign HPROT      = hprot_q;
  assign HTRANS     = htrans_q;
  assign rsp0_valid = rsp_vld_q[0];
  assign rsp1_valid = rsp_vld_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp_rdata  = rdata_q;
endmodule

// File: tb/tb_ahb3lite_rr_master_arb.sv
// Directed bench for ahb3lite_rr_master_arb with a small wait-state/error-capable slave.
module tb_ahb3lite_rr_master_arb;
  logic        HCLK = 1'b0, HRESET;
  logic        req0_valid, req0_ready, req0_write, req1_valid, req1_ready, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [2:0]  req0_size, req1_size;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
  logic        HSEL, HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  int n_cmp = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_rr_master_arb dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_size(req0_size),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_size(req1_size),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
    .rsp_rdata(rsp_rdata), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // Slave memory: word-indexed, stores writes on the completing data-phase edge.
  logic [31:0] mem [0:63];
  logic        dp_act, dp_wr;
  logic [5:0]  dp_a;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_act <= 1'b0; dp_wr <= 1'b0; dp_a <= '0;
    end else if (HREADY) begin
      if (dp_act && dp_wr) mem[dp_a] <= HWDATA;
      dp_act <= HSEL && (HTRANS == 2'b10);
      dp_wr  <= HWRITE;
      dp_a   <= HADDR[7:2];
    end
  end

  // Garbage while stalled, so capture on the wrong edge is visible.
  assign HRDATA = HREADY ? mem[dp_a] : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic drv(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] s);
    if (p == 0) begin req0_valid = 1; req0_write = w; req0_addr = a; req0_wdata = d; req0_size = s; end
    else        begin req1_valid = 1; req1_write = w; req1_addr = a; req1_wdata = d; req1_size = s; end
  endtask

  task automatic test_reset();
    HRESET = 1; HREADY = 1; HRESP = 0;
    req0_valid = 0; req1_valid = 0; req0_write = 0; req1_write = 0;
    req0_addr = 0; req1_addr = 0; req0_wdata = 0; req1_wdata = 0; req0_size = 0; req1_size = 0;
    tick(); req0_valid = 1;
    tick();
    @(negedge HCLK);
    n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b exp 0", req0_ready); end
    n_cmp++; if (HSEL !== 1'b0 || HTRANS !== 2'b00) begin n_err++; $display("FAIL rst_bus: HSEL %b HTRANS %b exp 0", HSEL, HTRANS); end
    n_cmp++; if (HADDR !== 0 || HWDATA !== 0 || HWRITE !== 0 || HSIZE !== 0 || HPROT !== 0 || HBURST !== 0) begin
      n_err++; $display("FAIL rst_ctl: HADDR %h HWDATA %h HWRITE %b HSIZE %h HPROT %h exp 0", HADDR, HWDATA, HWRITE, HSIZE, HPROT); end
    n_cmp++; if (rsp0_valid !== 0 || rsp1_valid !== 0 || rsp_rdata !== 0) begin
      n_err++; $display("FAIL rst_rsp: v0 %b v1 %b rdata %h exp 0", rsp0_valid, rsp1_valid, rsp_rdata); end
    tick(); HRESET = 0; req0_valid = 0;
  endtask

  task automatic test_write_read();
    drv(0, 1, 32'h10, 32'hDEADBEEF, 3'd2);
    @(negedge HCLK);
    n_cmp++; if (req0_ready !== 1 || req1_ready !== 0) begin n_err++; $display("FAIL wr_ready: got %b%b exp 01", req1_ready, req0_ready); end
    tick(); req0_valid = 0;
    @(negedge HCLK);
    n_cmp++; if (HTRANS !== 2'b10 || HSEL !== 1) begin n_err++; $display("FAIL wr_nonseq: HTRANS %b HSEL %b exp 10/1", HTRANS, HSEL); end
    n_cmp++; if (HADDR !== 32'h10 || HWRITE !== 1 || HSIZE !== 3'd2 || HPROT !== 4'b0011 || HBURST !== 0) begin
      n_err++; $display("FAIL wr_actl: HADDR %h HWRITE %b HSIZE %h HPROT %h HBURST %h exp 10/1/2/3/0", HADDR, HWRITE, HSIZE, HPROT, HBURST); end
    tick(); @(negedge HCLK);
    n_cmp++; if (HTRANS !== 2'b00 || HWDATA !== 32'hDEADBEEF || rsp0_valid !== 0) begin
      n_err++; $display("FAIL wr_dphase: HTRANS %b HWDATA %h rsp0 %b exp 00/deadbeef/0", HTRANS, HWDATA, rsp0_valid); end
    tick(); drv(0, 0, 32'h10, 32'h0, 3'd2);
    @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 1 || rsp0_err !== 0 || rsp1_valid !== 0) begin
      n_err++; $display("FAIL wr_rsp: v0 %b err %b v1 %b exp 1/0/0", rsp0_valid, rsp0_err, rsp1_valid); end
    n_cmp++; if (req0_ready !== 1) begin n_err++; $display("FAIL rd_ready_in_rsp: got %b exp 1", req0_ready); end
    tick(); req0_valid = 0;
    @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 0 || HWRITE !== 0) begin n_err++; $display("FAIL rd_addr: rsp0 %b HWRITE %b exp 0/0", rsp0_valid, HWRITE); end
    tick(); tick(); @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 1 || rsp_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rd_data: v0 %b rdata %h exp 1/deadbeef", rsp0_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    int gnt [4];
    int cyc [4];
    int ng = 0;
    HRESET = 1; tick();
    HRESET = 0; drv(0, 0, 32'h0, 32'h0, 3'd2); drv(1, 0, 32'h4, 32'h0, 3'd2);
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge HCLK);
      if (req0_ready || req1_ready) begin
        n_cmp++; if (req0_ready && req1_ready) begin n_err++; $display("FAIL rr_both_ready: got 11 exp one-hot"); end
        gnt[ng] = int'(req1_ready); cyc[ng] = c; ng++;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    n_cmp++; if (ng != 4) begin n_err++; $display("FAIL rr_timeout: got %0d grants exp 4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_cmp++; if (gnt[i] != i % 2) begin n_err++; $display("FAIL rr_grant%0d: got %0d exp %0d", i, gnt[i], i % 2); end
      if (i > 0) begin
        n_cmp++; if (cyc[i] - cyc[i-1] != 3) begin n_err++; $display("FAIL rr_gap%0d: got %0d exp 3", i, cyc[i] - cyc[i-1]); end
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_wait_states();
    drv(0, 0, 32'h20, 32'h0, 3'd2);
    @(negedge HCLK);
    n_cmp++; if (req0_ready !== 1) begin n_err++; $display("FAIL ws_ready: got %b exp 1", req0_ready); end
    tick(); req0_valid = 0; drv(1, 0, 32'h8, 32'h0, 3'd2);
    @(negedge HCLK);
    n_cmp++; if (HTRANS !== 2'b10 || req1_ready !== 0) begin n_err++; $display("FAIL ws_addr: HTRANS %b rdy1 %b exp 10/0", HTRANS, req1_ready); end
    tick(); HREADY = 0;
    for (int w = 0; w < 3; w++) begin
      @(negedge HCLK);
      n_cmp++; if (HTRANS !== 2'b00 || HSEL !== 0 || HADDR !== 32'h20 || rsp0_valid !== 0 || req1_ready !== 0) begin
        n_err++; $display("FAIL ws_hold%0d: HTRANS %b HSEL %b HADDR %h rsp0 %b rdy1 %b", w, HTRANS, HSEL, HADDR, rsp0_valid, req1_ready); end
      tick();
    end
    HREADY = 1;
    @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 0 || req1_ready !== 0) begin n_err++; $display("FAIL ws_early: rsp0 %b rdy1 %b exp 0/0", rsp0_valid, req1_ready); end
    tick(); @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 1 || rsp0_err !== 0 || rsp_rdata !== 32'hC0DE_0008) begin
      n_err++; $display("FAIL ws_rsp: v0 %b err %b rdata %h exp 1/0/c0de0008", rsp0_valid, rsp0_err, rsp_rdata); end
    n_cmp++; if (req1_ready !== 1) begin n_err++; $display("FAIL ws_next_grant: got %b exp 1", req1_ready); end
    tick(); req1_valid = 0;
    repeat (4) tick();
  endtask

  task automatic test_error_resp();
    drv(1, 1, 32'h30, 32'h12345678, 3'd2);
    @(negedge HCLK);
    n_cmp++; if (req1_ready !== 1) begin n_err++; $display("FAIL er_ready: got %b exp 1", req1_ready); end
    tick(); req1_valid = 0;
    tick(); HRESP = 1; HREADY = 0;
    @(negedge HCLK);
    n_cmp++; if (HWDATA !== 32'h12345678 || rsp1_valid !== 0) begin n_err++; $display("FAIL er_first: HWDATA %h rsp1 %b exp 12345678/0", HWDATA, rsp1_valid); end
    tick(); HREADY = 1;
    @(negedge HCLK);
    n_cmp++; if (rsp1_valid !== 0) begin n_err++; $display("FAIL er_second: rsp1 %b exp 0", rsp1_valid); end
    tick(); HRESP = 0; drv(0, 0, 32'h10, 32'h0, 3'd2);
    @(negedge HCLK);
    n_cmp++; if (rsp1_valid !== 1 || rsp1_err !== 1 || rsp0_valid !== 0 || req0_ready !== 1) begin
      n_err++; $display("FAIL er_rsp: v1 %b err1 %b v0 %b rdy0 %b exp 1/1/0/1", rsp1_valid, rsp1_err, rsp0_valid, req0_ready); end
    tick(); req0_valid = 0;
    @(negedge HCLK);
    n_cmp++; if (rsp1_valid !== 0 || rsp1_err !== 0) begin n_err++; $display("FAIL er_pulse: v1 %b err1 %b exp 0/0", rsp1_valid, rsp1_err); end
    tick(); tick(); @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 1 || rsp0_err !== 0 || rsp_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL er_after: v0 %b err %b rdata %h exp 1/0/deadbeef", rsp0_valid, rsp0_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_reject();
    drv(0, 0, 32'h13, 32'h0, 3'd2);
    @(negedge HCLK);
    n_cmp++; if (req0_ready !== 1) begin n_err++; $display("FAIL rj_ready0: got %b exp 1", req0_ready); end
    tick(); req0_valid = 0;
    @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 1 || rsp0_err !== 1 || rsp_rdata !== 0 || HTRANS !== 0 || HSEL !== 0) begin
      n_err++; $display("FAIL rj_misalign: v0 %b err %b rdata %h HTRANS %b HSEL %b exp 1/1/0/00/0", rsp0_valid, rsp0_err, rsp_rdata, HTRANS, HSEL); end
    tick(); drv(1, 0, 32'h18, 32'h0, 3'd3);
    @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 0 || req1_ready !== 1) begin n_err++; $display("FAIL rj_ready1: rsp0 %b rdy1 %b exp 0/1", rsp0_valid, req1_ready); end
    tick(); req1_valid = 0;
    @(negedge HCLK);
    n_cmp++; if (rsp1_valid !== 1 || rsp1_err !== 1 || HTRANS !== 0 || HSEL !== 0) begin
      n_err++; $display("FAIL rj_size: v1 %b err %b HTRANS %b HSEL %b exp 1/1/00/0", rsp1_valid, rsp1_err, HTRANS, HSEL); end
    tick();
  endtask

  task automatic test_reset_mid();
    drv(0, 0, 32'h20, 32'h0, 3'd2);
    tick(); req0_valid = 0;
    tick(); HREADY = 0; HRESET = 1;
    tick(); HREADY = 1; HRESET = 0; drv(0, 0, 32'h0, 32'h0, 3'd2); drv(1, 0, 32'h4, 32'h0, 3'd2);
    @(negedge HCLK);
    n_cmp++; if (HSEL !== 0 || HTRANS !== 0 || HADDR !== 0 || HWRITE !== 0 || HSIZE !== 0 || HPROT !== 0 || HWDATA !== 0) begin
      n_err++; $display("FAIL rm_bus: HSEL %b HTRANS %b HADDR %h HSIZE %h HPROT %h exp 0", HSEL, HTRANS, HADDR, HSIZE, HPROT); end
    n_cmp++; if (rsp0_valid !== 0 || rsp1_valid !== 0 || rsp_rdata !== 0) begin
      n_err++; $display("FAIL rm_rsp: v0 %b v1 %b rdata %h exp 0", rsp0_valid, rsp1_valid, rsp_rdata); end
    n_cmp++; if (req0_ready !== 1 || req1_ready !== 0) begin n_err++; $display("FAIL rm_first_grant: got %b%b exp 01", req1_ready, req0_ready); end
    tick(); req0_valid = 0; req1_valid = 0;
    @(negedge HCLK);
    n_cmp++; if (rsp0_valid !== 0 || rsp1_valid !== 0) begin n_err++; $display("FAIL rm_stale: v0 %b v1 %b exp 0/0", rsp0_valid, rsp1_valid); end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_wait_states();
    test_error_resp();
    test_reject();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
